// File: rtl/sipo_ctrl_pkg.sv
// rtl/sipo_ctrl_pkg.sv - shared types and defaults for the serial-in frame controller
package sipo_ctrl_pkg;

    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } state_t;

endpackage

// File: rtl/sipo_shreg.sv
// rtl/sipo_shreg.sv - right-shifting serial-in parallel-out register, new bit enters at the MSB
module sipo_shreg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              din,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= {din, q[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// rtl/sipo_frame_ctrl.sv - start/data/stop frame receiver with a one-entry valid/ready output holding register
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_tick,
    input  logic              ser_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frm_err,
    output logic              ovr_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg_q;
    logic              shift_en;

    assign shift_en = (state == DATA) & bit_tick;
    assign busy     = (state != IDLE);

    sipo_shreg #(
        .DATA_W(DATA_W)
    ) u_shreg (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (shift_en),
        .din  (ser_in),
        .q    (shreg_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frm_err   <= 1'b0;
            ovr_err   <= 1'b0;
        end else begin
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
            // A delivery later in this block overrides this clear, keeping valid high across back-to-back bytes.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (bit_tick) begin
                case (state)
                    IDLE: begin
                        if (!ser_in) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!ser_in) begin
                            frm_err <= 1'b1;
                        end else if (!out_valid || out_ready) begin
                            out_data  <= shreg_q;
                            out_valid <= 1'b1;
                        end else begin
                            ovr_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb/tb_sipo_frame_ctrl.sv - scoreboard bench for sipo_frame_ctrl with directed frames
module tb_sipo_frame_ctrl;
    import sipo_ctrl_pkg::*;

    localparam int DATA_W = DEF_DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              bit_tick = 1'b0;
    logic              ser_in = 1'b1;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              frm_err;
    logic              ovr_err;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;
    int frm_seen = 0;
    int ovr_seen = 0;
    int exp_frm = 0;
    int exp_ovr = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic              hold_prev = 1'b0;
    logic [DATA_W-1:0] hold_data = '0;

    sipo_frame_ctrl #(
        .DATA_W(DATA_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bit_tick (bit_tick),
        .ser_in   (ser_in),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frm_err  (frm_err),
        .ovr_err  (ovr_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: consumes a scoreboard entry on every transfer and counts error pulses.
    always @(negedge clk) begin
        if (frm_err === 1'b1) frm_seen++;
        if (ovr_err === 1'b1) ovr_seen++;
        if (out_valid === 1'b1 && hold_prev) begin
            check("hold_stable", 32'(out_data), 32'(hold_data));
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got 0x%0h expected none at %0t", out_data, $time);
            end else begin
                check("scoreboard", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
        hold_prev = (out_valid === 1'b1 && out_ready === 1'b0);
        hold_data = out_data;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic rdy_on_tick);
        ser_in   = b;
        bit_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bit_tick = 1'b1;
        if (rdy_on_tick) out_ready = 1'b1;
        @(posedge clk);
        #1;
        bit_tick = 1'b0;
        if (rdy_on_tick) out_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic stop, input logic rdy_on_stop);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < DATA_W; i++) send_bit(d[i], 1'b0);
        send_bit(stop, rdy_on_stop);
        ser_in = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("idle_busy", 32'(busy), 0);
        check("idle_valid", 32'(out_valid), 0);
        check("idle_frm", 32'(frm_err), 0);
        check("idle_ovr", 32'(ovr_err), 0);

        // Good frame, consumer always ready.
        out_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        check("a5_valid_rise", 32'(out_valid), 1);
        check("a5_data", 32'(out_data), 32'h A5);
        check("a5_busy", 32'(busy), 0);
        cycles(1);
        check("a5_valid_fall", 32'(out_valid), 0);

        // Bad stop bit.
        send_frame(8'h3C, 1'b0, 1'b0);
        exp_frm++;
        check("3c_frm_pulse", 32'(frm_err), 1);
        check("3c_valid", 32'(out_valid), 0);
        check("3c_busy", 32'(busy), 0);
        cycles(1);
        check("3c_frm_end", 32'(frm_err), 0);
        check("3c_frm_count", frm_seen, exp_frm);

        // Overrun: second frame dropped while the first is unconsumed.
        out_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        check("ovr_first_valid", 32'(out_valid), 1);
        send_frame(8'h22, 1'b1, 1'b0);
        exp_ovr++;
        check("ovr_pulse", 32'(ovr_err), 1);
        check("ovr_data_kept", 32'(out_data), 32'h11);
        cycles(1);
        check("ovr_pulse_end", 32'(ovr_err), 0);
        check("ovr_count", ovr_seen, exp_ovr);
        cycles(2);
        out_ready = 1'b1;
        cycles(1);
        out_ready = 1'b0;
        check("ovr_drain_valid", 32'(out_valid), 0);

        // Consume and deliver on the same edge.
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1, 1'b1);
        check("swap_valid", 32'(out_valid), 1);
        check("swap_data", 32'(out_data), 32'h22);
        check("swap_no_ovr", 32'(ovr_err), 0);
        cycles(1);
        check("swap_ovr_count", ovr_seen, exp_ovr);
        out_ready = 1'b1;
        cycles(1);
        out_ready = 1'b0;
        check("swap_drain_valid", 32'(out_valid), 0);

        // Reset mid-frame, then a clean frame.
        out_ready = 1'b1;
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_valid", 32'(out_valid), 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        check("5a_valid", 32'(out_valid), 1);
        check("5a_data", 32'(out_data), 32'h5A);
        cycles(1);
        check("5a_frm_count", frm_seen, exp_frm);
        check("5a_ovr_count", ovr_seen, exp_ovr);

        cycles(3);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sipo_frame_ctrl.md
SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning payload bits per frame; legal range 2..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port bit_tick, input, 1, sample strobe; the line is sampled only on cycles with bit_tick=1.
REQ-005 SHALL have port ser_in, input, 1, serial line; idle high.
REQ-006 SHALL have port out_data, output, DATA_W, received payload.
REQ-007 SHALL have port out_valid, output, 1, out_data holds an unconsumed byte.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts out_data.
REQ-009 SHALL have port frm_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port ovr_err, output, 1, one-cycle pulse on a dropped frame.
REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, DATA and STOP; the state is held on cycles with bit_tick=0.
REQ-013 IDLE: on bit_tick with ser_in=0 (start bit), SHALL go to DATA and clear bit_cnt to 0; ser_in=1 SHALL stay in IDLE.
REQ-014 DATA: each bit_tick SHALL shift ser_in into the MSB of the shift register (right shift, LSB-first framing) and increment bit_cnt.
REQ-015 DATA: the tick that samples bit DATA_W-1 SHALL move to STOP; bit_cnt width SHALL be clog2(DATA_W)+1 with no wrap inside a frame.
REQ-016 STOP, bit_tick, ser_in=1: SHALL go to IDLE and deliver the shift-register contents per REQ-018..020.
REQ-017 STOP, bit_tick, ser_in=0: SHALL go to IDLE, pulse frm_err for exactly one cycle, and discard the byte; out_data and out_valid are unchanged.
REQ-018 Delivery with out_valid=0: out_data SHALL load at that edge, with out_valid=1 from the next cycle.
REQ-019 Delivery with out_valid=1 and out_ready=1 in the same cycle: the old byte is consumed, the new byte loads, and out_valid stays 1.
REQ-020 Delivery with out_valid=1 and out_ready=0: the new byte is dropped, ovr_err pulses for one cycle, and the old out_data is retained.
REQ-021 Handshake: a transfer occurs on the edge where out_valid=1 and out_ready=1; with no simultaneous delivery, out_valid SHALL clear on the next cycle.
REQ-022 out_data SHALL be stable while out_valid=1 and out_ready=0; out_ready is ignored when out_valid=0.
REQ-023 Delivery latency: out_valid SHALL rise 1 cycle after the stop-bit tick edge.
REQ-024 Back-to-back frames: the controller SHALL accept a start bit on the first tick after returning to IDLE.

Reset
REQ-025 While rst_n=0 at a clock edge: state=IDLE, bit_cnt=0, shift register=0, out_data=0, out_valid=0, frm_err=0, ovr_err=0, busy=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no error pulse; reset has priority over bit_tick and the handshake.

Structure
REQ-027 Package sipo_ctrl_pkg SHALL hold the state enum (IDLE, DATA, STOP) and the constant DEF_DATA_W=8.
REQ-028 The shift register SHALL be the sub-module sipo_shreg (ports: clk, rst_n, en, din, q[DATA_W]); this controller drives en = (state==DATA) & bit_tick.

Verification
REQ-029 rst_n low 2 cycles, then idle line: all outputs 0; busy=0.
REQ-030 Frame start=0, data 0xA5 LSB-first, stop=1, tick every 4 cycles, out_ready=1: out_data=0xA5, with out_valid high for 1 cycle beginning 1 cycle after the stop tick.
REQ-031 Frame 0x3C with stop=0: frm_err high for 1 cycle, out_valid stays 0, state returns to IDLE.
REQ-032 Two frames 0x11 then 0x22 with out_ready=0: out_data=0x11 held, ovr_err pulses once at the second stop tick; raising out_ready then consumes 0x11 and out_valid falls.
REQ-033 Second frame completing in the same cycle as out_ready=1: out_data changes 0x11->0x22 with out_valid continuously 1 and no ovr_err.
REQ-034 rst_n low for 1 cycle after 4 data bits, then a full frame 0x5A: no error pulses, and out_data=0x5A.
